// File: rtl/bic_pkg.sv
// Shared helpers for the segmented bus-invert encoder.
// Width helpers, popcount and saturating accumulate used by the stats option.
package bic_pkg;

   localparam int STAT_W = 32;
   localparam int PC_MAX = 64;

   function automatic int cnt_w(input int seg_w);
      return $clog2(seg_w + 1);
   endfunction

   function automatic int cost_w(input int seg_w);
      return cnt_w(seg_w) + 1;
   endfunction

   // Segments wider than PC_MAX bits are not supported.
   function automatic logic [7:0] popcount(input logic [PC_MAX-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int b = 0; b < PC_MAX; b++) begin
         n = n + 8'(v[b]);
      end
      return n;
   endfunction

   function automatic logic [STAT_W-1:0] sat_add(
      input logic [STAT_W-1:0] a,
      input logic [STAT_W-1:0] b
   );
      logic [STAT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STAT_W] ? '1 : s[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/bic_seg_decide.sv
// One segment of the bus-invert decision: compares toggle cost of the
// true and inverted word against the value currently held on the bus.
module bic_seg_decide
   import bic_pkg::*;
#(
   parameter int SEG_W = 8
) (
   input  logic [SEG_W-1:0]         s_seg,
   input  logic [SEG_W-1:0]         prev_seg,
   input  logic                     prev_inv,
   input  logic                     bic_en,
   output logic [SEG_W-1:0]         enc_seg,
   output logic                     inv,
   output logic [cost_w(SEG_W)-1:0] saved
);

   localparam int CW = cnt_w(SEG_W);
   localparam int KW = cost_w(SEG_W);

   logic [CW-1:0] p;
   logic [KW-1:0] cost_true;
   logic [KW-1:0] cost_inv;
   logic          do_inv;

   assign p         = CW'(popcount(PC_MAX'(s_seg ^ prev_seg)));
   assign cost_true = KW'(p) + KW'(prev_inv);
   assign cost_inv  = KW'(SEG_W) - KW'(p) + KW'(!prev_inv);

   // Strict compare: a tie keeps the true polarity.
   assign do_inv  = bic_en && (cost_inv < cost_true);
   assign enc_seg = do_inv ? ~s_seg : s_seg;
   assign inv     = do_inv;
   assign saved   = do_inv ? (cost_true - cost_inv) : '0;

endmodule

// File: rtl/bic_encoder_pipe.sv
// Registered segmented bus-invert encoder behind a valid/ready handshake.
// Optional BIC_STATS_EN adds inversion / saved-toggle counters.
module bic_encoder_pipe
   import bic_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SEG_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bic_en,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [DATA_W-1:0]        s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_W-1:0]        m_data,
`ifdef BIC_STATS_EN
   input  logic                     stat_clr,
   output logic [STAT_W-1:0]        stat_inv_cnt,
   output logic [STAT_W-1:0]        stat_saved,
`endif
   output logic [DATA_W/SEG_W-1:0]  m_inv
);

   localparam int NSEG = DATA_W / SEG_W;
   localparam int KW   = cost_w(SEG_W);

   logic                        accept;
   logic [DATA_W-1:0]           enc_data;
   logic [NSEG-1:0]             enc_inv;
   logic [NSEG-1:0][KW-1:0]     seg_saved;

   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      bic_seg_decide #(.SEG_W(SEG_W)) u_dec (
         .s_seg    (s_data[k*SEG_W +: SEG_W]),
         .prev_seg (m_data[k*SEG_W +: SEG_W]),
         .prev_inv (m_inv[k]),
         .bic_en   (bic_en),
         .enc_seg  (enc_data[k*SEG_W +: SEG_W]),
         .inv      (enc_inv[k]),
         .saved    (seg_saved[k])
      );
   end

   // Bus state only moves on accept, so it doubles as the reference.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_inv   <= '0;
      end else if (accept) begin
         m_valid <= 1'b1;
         m_data  <= enc_data;
         m_inv   <= enc_inv;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

`ifdef BIC_STATS_EN
   logic [STAT_W-1:0] inv_sum;
   logic [STAT_W-1:0] saved_sum;

   always_comb begin
      inv_sum   = '0;
      saved_sum = '0;
      for (int k = 0; k < NSEG; k++) begin
         inv_sum   = inv_sum + STAT_W'(enc_inv[k]);
         saved_sum = saved_sum + STAT_W'(seg_saved[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         stat_inv_cnt <= '0;
         stat_saved   <= '0;
      end else if (accept) begin
         stat_inv_cnt <= sat_add(stat_inv_cnt, inv_sum);
         stat_saved   <= sat_add(stat_saved, saved_sum);
      end
   end
`else
   logic unused_saved;
   assign unused_saved = ^seg_saved;
`endif

endmodule

// File: tb/tb_bic_encoder_pipe.sv
// Directed bench for bic_encoder_pipe at DATA_W=16, SEG_W=8.
// Vector table plus hand-written backpressure and reset sequences.
module tb_bic_encoder_pipe;

   localparam int DW = 16;
   localparam int SW = 8;
   localparam int NS = DW / SW;

   logic          clk = 1'b0;
   logic          rst;
   logic          bic_en;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [NS-1:0] m_inv;
`ifdef BIC_STATS_EN
   logic          stat_clr;
   logic [31:0]   stat_inv_cnt;
   logic [31:0]   stat_saved;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bic_encoder_pipe #(.DATA_W(DW), .SEG_W(SW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bic_en       (bic_en),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
`ifdef BIC_STATS_EN
      .stat_clr     (stat_clr),
      .stat_inv_cnt (stat_inv_cnt),
      .stat_saved   (stat_saved),
`endif
      .m_inv        (m_inv)
   );

   typedef struct {
      logic          do_rst;
      logic          en;
      logic [DW-1:0] data;
      logic [DW-1:0] exp_data;
      logic [NS-1:0] exp_inv;
   } vec_t;

   vec_t vecs [10];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      bic_en  = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
`ifdef BIC_STATS_EN
      stat_clr = 1'b0;
`endif

      vecs[0] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 2'b11};
      vecs[1] = '{1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 2'b11};
      vecs[2] = '{1'b1, 1'b1, 16'h000F, 16'h000F, 2'b00};
      vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 2'b00};
      vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 2'b11};
      vecs[5] = '{1'b0, 1'b1, 16'h00FF, 16'hFFFF, 2'b10};
      vecs[6] = '{1'b0, 1'b1, 16'h1234, 16'hEDCB, 2'b11};
      vecs[7] = '{1'b0, 1'b1, 16'hEDCB, 16'hEDCB, 2'b00};
      vecs[8] = '{1'b1, 1'b1, 16'h001F, 16'h00E0, 2'b01};
      vecs[9] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00};

      tick();
      rst = 1'b0;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'h0);
      chk("rst_m_inv", 32'(m_inv), 32'h0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef BIC_STATS_EN
      chk("rst_stat_inv", stat_inv_cnt, 32'd0);
      chk("rst_stat_saved", stat_saved, 32'd0);
`endif

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].do_rst) do_reset();
         bic_en  = vecs[i].en;
         s_data  = vecs[i].data;
         s_valid = 1'b1;
         m_ready = 1'b1;
         tick();
         s_valid = 1'b0;
         chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'd1);
         chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_m_inv", i), 32'(m_inv), 32'(vecs[i].exp_inv));
         s_data = ~vecs[i].data;
         tick();
         chk($sformatf("v%0d_idle_valid", i), 32'(m_valid), 32'd0);
         chk($sformatf("v%0d_idle_data", i), 32'(m_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_idle_inv", i), 32'(m_inv), 32'(vecs[i].exp_inv));
      end

      // Backpressure: bus is 0x0000 / 00 after the last vector.
      bic_en  = 1'b1;
      m_ready = 1'b0;
      s_data  = 16'h0F00;
      s_valid = 1'b1;
      tick();
      s_data = 16'hFFFF;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_s_ready", c), 32'(s_ready), 32'd0);
         chk($sformatf("bp%0d_m_valid", c), 32'(m_valid), 32'd1);
         chk($sformatf("bp%0d_m_data", c), 32'(m_data), 32'h0F00);
         chk($sformatf("bp%0d_m_inv", c), 32'(m_inv), 32'h0);
         tick();
      end
      m_ready = 1'b1;
      #1;
      chk("bp_release_s_ready", 32'(s_ready), 32'd1);
      tick();
      chk("bp_next_m_valid", 32'(m_valid), 32'd1);
      chk("bp_next_m_data", 32'(m_data), 32'hFF00);
      chk("bp_next_m_inv", 32'(m_inv), 32'h1);

      // Reset while a word is held under backpressure.
      s_valid = 1'b0;
      m_ready = 1'b0;
      tick();
      chk("mid_pre_valid", 32'(m_valid), 32'd1);
      do_reset();
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_data", 32'(m_data), 32'h0);
      chk("mid_rst_inv", 32'(m_inv), 32'h0);

`ifdef BIC_STATS_EN
      m_ready = 1'b1;
      s_data  = 16'hFFFF;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("stat_inv_cnt", stat_inv_cnt, 32'd2);
      chk("stat_saved", stat_saved, 32'd14);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("stat_clr_inv", stat_inv_cnt, 32'd0);
      chk("stat_clr_saved", stat_saved, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
